// File: rtl/vector_reg_file_param_if.sv
// Operand/result bus between vector decode, the register file and ALU lanes.
// Carries read/write addressing, masked write data, clear handshake, status.
interface vector_reg_file_param_if #(
  parameter int ADDR_W = 3,
  parameter int VLEN   = 256,
  parameter int LANES  = 8
);
  logic              Vstart;
  logic [ADDR_W-1:0] VreadA;
  logic [ADDR_W-1:0] VreadB;
  logic              VwrEn;
  logic [ADDR_W-1:0] VwrAddr;
  logic [VLEN-1:0]   Vwrdata;
  logic [LANES-1:0]  VwrMask;
  logic              Vclear;
  logic [VLEN-1:0]   Va;
  logic [VLEN-1:0]   Vb;
  logic              Vbusy;
  logic              Vdone;
  logic              VparErr;

  modport master (
    output Vstart, VreadA, VreadB, VwrEn, VwrAddr,
    output Vwrdata, VwrMask, Vclear,
    input  Va, Vb, Vbusy, Vdone, VparErr
  );

  modport slave (
    input  Vstart, VreadA, VreadB, VwrEn, VwrAddr,
    input  Vwrdata, VwrMask, Vclear,
    output Va, Vb, Vbusy, Vdone, VparErr
  );
endinterface

// File: rtl/vector_reg_file_param.sv
// Parametrised vector register file: masked writes, bypass, bulk clear.
// Optional per-lane parity storage/check under macro VRF_PARITY_EN.
module vector_reg_file_param #(
  parameter int NUM_REGS = 8,
  parameter int VLEN     = 256,
  parameter int LANE_W   = 32,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    Vreset,
  vector_reg_file_param_if.slave  bus
);
  localparam int LANES  = VLEN / LANE_W;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              wr_acc;
  logic              byp_a, byp_b;
  logic [VLEN-1:0]   mem_q [NUM_REGS];
  logic [VLEN-1:0]   va_q, va_d;
  logic [VLEN-1:0]   vb_q, vb_d;
  logic [VLEN-1:0]   merged;

  always_comb begin
    merged = mem_q[bus.VwrAddr];
    for (int l = 0; l < LANES; l++) begin
      if (bus.VwrMask[l])
        merged[l*LANE_W +: LANE_W] = bus.Vwrdata[l*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_acc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Vclear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (bus.VwrEn && bus.Vstart) begin
          wr_acc = 1'b1;
          done_d = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
    endcase
  end

  assign byp_a = (BYPASS != 0) && wr_acc && (bus.VreadA == bus.VwrAddr);
  assign byp_b = (BYPASS != 0) && wr_acc && (bus.VreadB == bus.VwrAddr);

  always_comb begin
    va_d = va_q;
    vb_d = vb_q;
    if (state_q == IDLE) begin
      va_d = byp_a ? merged : mem_q[bus.VreadA];
      vb_d = byp_b ? merged : mem_q[bus.VreadB];
    end
  end

  always_ff @(posedge clk or negedge Vreset) begin
    if (!Vreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      va_q    <= '0;
      vb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  always_ff @(posedge clk or negedge Vreset) begin
    if (!Vreset) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else if (wr_acc) begin
      mem_q[bus.VwrAddr] <= merged;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end
  end

  assign bus.Va    = va_q;
  assign bus.Vb    = vb_q;
  assign bus.Vbusy = (state_q == CLEAR);
  assign bus.Vdone = done_q;

`ifdef VRF_PARITY_EN
  logic [LANES-1:0] par_q [NUM_REGS];
  logic [LANES-1:0] par_new;
  logic             err_q, err_d;

  function automatic logic [LANES-1:0] lane_par(input logic [VLEN-1:0] d);
    logic [LANES-1:0] p;
    for (int l = 0; l < LANES; l++) p[l] = ^d[l*LANE_W +: LANE_W];
    return p;
  endfunction

  // Unmasked lanes keep their stored bit so latent corruption stays visible.
  always_comb begin
    par_new = par_q[bus.VwrAddr];
    for (int l = 0; l < LANES; l++) begin
      if (bus.VwrMask[l])
        par_new[l] = ^bus.Vwrdata[l*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE) begin
      err_d = (!byp_a &&
               |(lane_par(mem_q[bus.VreadA]) ^ par_q[bus.VreadA])) ||
              (!byp_b &&
               |(lane_par(mem_q[bus.VreadB]) ^ par_q[bus.VreadB]));
    end
  end

  always_ff @(posedge clk or negedge Vreset) begin
    if (!Vreset) begin
      for (int r = 0; r < NUM_REGS; r++) par_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (wr_acc) par_q[bus.VwrAddr] <= par_new;
      else if (state_q == CLEAR) par_q[cnt_q] <= '0;
    end
  end

  assign bus.VparErr = err_q;
`else
  assign bus.VparErr = 1'b0;
`endif
endmodule

// File: tb/tb_vector_reg_file_param.sv
// Randomised and directed checks of vector_reg_file_param against
// an array-based reference model of the register file.
module tb_vector_reg_file_param;
  localparam int N      = 8;
  localparam int VLEN   = 256;
  localparam int LANE_W = 32;
  localparam int LANES  = VLEN / LANE_W;
  localparam int AW     = 3;
  localparam int BYPASS = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_reg_file_param_if #(.ADDR_W(AW), .VLEN(VLEN), .LANES(LANES)) bus ();

  vector_reg_file_param #(
    .NUM_REGS(N), .VLEN(VLEN), .LANE_W(LANE_W), .BYPASS(BYPASS)
  ) dut (
    .clk(clk),
    .Vreset(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [VLEN-1:0] model [N];
  logic [VLEN-1:0] exp_va, exp_vb;
  int clr_left;

  task automatic chk(input string tag,
                     input logic [VLEN-1:0] got,
                     input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] rnd_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = $urandom;
    return v;
  endfunction

  function automatic logic [VLEN-1:0] merge(input logic [VLEN-1:0] old,
                                            input logic [VLEN-1:0] nw,
                                            input logic [LANES-1:0] m);
    logic [VLEN-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*LANE_W +: LANE_W] = m[i] ? nw[i*LANE_W +: LANE_W]
                                   : old[i*LANE_W +: LANE_W];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = '0;
    exp_va = '0;
    exp_vb = '0;
    clr_left = 0;
  endtask

  task automatic drive(input bit en, input bit st, input int wa,
                       input logic [VLEN-1:0] d, input logic [LANES-1:0] m,
                       input int ra, input int rb, input bit clr);
    bus.VwrEn   = en;
    bus.Vstart  = st;
    bus.VwrAddr = AW'(wa);
    bus.Vwrdata = d;
    bus.VwrMask = m;
    bus.VreadA  = AW'(ra);
    bus.VreadB  = AW'(rb);
    bus.Vclear  = clr;
  endtask

  // One clock: predict from the pre-edge model, then compare after the edge.
  task automatic cycle();
    logic [VLEN-1:0] mrg, ea, eb;
    bit acc, go, done_e;
    int wa;
    acc = 0; go = 0; done_e = 0;
    ea = exp_va; eb = exp_vb;
    wa = int'(bus.VwrAddr);
    mrg = merge(model[wa], bus.Vwrdata, bus.VwrMask);
    if (clr_left == 0) begin
      go  = bus.Vclear;
      acc = !bus.Vclear && bus.VwrEn && bus.Vstart;
      ea  = (BYPASS != 0 && acc && bus.VreadA == bus.VwrAddr)
            ? mrg : model[bus.VreadA];
      eb  = (BYPASS != 0 && acc && bus.VreadB == bus.VwrAddr)
            ? mrg : model[bus.VreadB];
      done_e = acc;
    end else begin
      done_e = (clr_left == 1);
    end
    @(posedge clk);
    #1;
    if (acc) model[wa] = mrg;
    if (go) begin
      for (int i = 0; i < N; i++) model[i] = '0;
      clr_left = N;
    end else if (clr_left > 0) begin
      clr_left--;
    end
    exp_va = ea;
    exp_vb = eb;
    chk("Va", bus.Va, exp_va);
    chk("Vb", bus.Vb, exp_vb);
    chk("Vbusy", VLEN'(bus.Vbusy), VLEN'(clr_left > 0));
    chk("Vdone", VLEN'(bus.Vdone), VLEN'(done_e));
    chk("VparErr", VLEN'(bus.VparErr), '0);
  endtask

  initial begin
    logic [VLEN-1:0] d;
    logic [LANES-1:0] m;
    model_reset();
    drive(0, 0, 0, '0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Va", bus.Va, '0);
    chk("rst_Vb", bus.Vb, '0);
    chk("rst_busy", VLEN'(bus.Vbusy), '0);
    chk("rst_done", VLEN'(bus.Vdone), '0);
    chk("rst_par", VLEN'(bus.VparErr), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full write of reg3, then read it back.
    drive(1, 1, 3, {LANES{32'hA5A5A5A5}}, '1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, '0, '0, 3, 3, 0);
    cycle();
    chk("a5_read", bus.Va, {LANES{32'hA5A5A5A5}});
    chk("a5_nodone", VLEN'(bus.Vdone), '0);

    // Partial lane write on reg2.
    drive(1, 1, 2, {LANES{32'h11111111}}, '1, 0, 0, 0);
    cycle();
    d = '0;
    d[31:0] = 32'hDEADBEEF;
    drive(1, 1, 2, d, 8'b0000_0001, 0, 0, 0);
    cycle();
    drive(0, 0, 0, '0, '0, 2, 2, 0);
    cycle();
    d = {LANES{32'h11111111}};
    d[31:0] = 32'hDEADBEEF;
    chk("mask_lane0", bus.Va, d);

    // Same-cycle bypass on reg5.
    drive(1, 1, 5, {LANES{32'h77777777}}, '1, 5, 3, 0);
    cycle();
    chk("bypass", bus.Va, {LANES{32'h77777777}});

    // Write without Vstart, then all-zero mask.
    drive(1, 0, 3, rnd_vec(), '1, 3, 3, 0);
    cycle();
    drive(1, 1, 3, rnd_vec(), '0, 3, 3, 0);
    cycle();
    drive(0, 0, 0, '0, '0, 3, 3, 0);
    cycle();

    // Fill, clear, with writes and a second clear attempted meanwhile.
    for (int i = 0; i < N; i++) begin
      drive(1, 1, i, rnd_vec(), '1, i, N - 1 - i, 0);
      cycle();
    end
    drive(1, 1, 4, rnd_vec(), '1, 4, 4, 1);
    cycle();
    for (int i = 0; i < N; i++) begin
      drive(1, 1, i, rnd_vec(), '1, i, i, (i == 2));
      cycle();
    end
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 0, '0, '0, i, i, 0);
      cycle();
    end

    // Asynchronous reset part-way through a clear.
    for (int i = 0; i < N; i++) begin
      drive(1, 1, i, rnd_vec(), '1, 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, '0, '0, 1, 6, 1);
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_Va", bus.Va, '0);
    chk("arst_Vb", bus.Vb, '0);
    chk("arst_busy", VLEN'(bus.Vbusy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 0, '0, '0, i, (i + 1) % N, 0);
      cycle();
    end

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: m = '1;
        1: m = '0;
        default: m = LANES'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, N - 1), rnd_vec(), m,
            $urandom_range(0, N - 1), $urandom_range(0, N - 1),
            $urandom_range(0, 49) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
